// File: rtl/baud_gen_frac_if.sv
// Control and tick bundle of the fractional baud-rate generator.
// The master side programs the divisor and gates counting. The slave side returns the ticks and the config error flag.
interface baud_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              os_tick;
  logic              bd_tick;
  logic              cfg_err;

  modport master (
    output en, div_int, div_frac, div_load,
    input  os_tick, bd_tick, cfg_err
  );

  modport slave (
    input  en, div_int, div_frac, div_load,
    output os_tick, bd_tick, cfg_err
  );
endinterface

// File: rtl/baud_gen_frac.sv
// Runtime-programmable baud generator: oversample tick with a first-order
// dithered fractional divisor, plus a bit tick on every OVS-th oversample tick.
module baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DEF_DIV  = 10,
  parameter int DEF_FRAC = 0
) (
  input  logic           clk,
  input  logic           rst,
  baud_gen_frac_if.slave bus
);
  localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int CNT_W = DIV_W + 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [OVS_W-1:0]  ovs_cnt_q, ovs_cnt_d;
  logic              os_tick_q, os_tick_d;
  logic              bd_tick_q, bd_tick_d;
  logic              cfg_err_q, cfg_err_d;
  logic [FRAC_W:0]   acc_sum;
  logic              wrap;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  assign wrap    = (cnt_q == per_q - CNT_W'(1));
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};

  always_comb begin
    div_d     = div_q;
    frac_d    = frac_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    ovs_cnt_d = ovs_cnt_q;
    cfg_err_d = cfg_err_q;
    os_tick_d = 1'b0;
    bd_tick_d = 1'b0;
    if (bus.div_load) begin
      // A load restarts generation from a clean phase and suppresses any due tick.
      div_d     = clamp_div(bus.div_int);
      frac_d    = bus.div_frac;
      acc_d     = '0;
      cnt_d     = '0;
      per_d     = {1'b0, clamp_div(bus.div_int)};
      ovs_cnt_d = '0;
      cfg_err_d = (bus.div_int < DIV_W'(2));
    end else if (bus.en) begin
      if (wrap) begin
        cnt_d     = '0;
        acc_d     = acc_sum[FRAC_W-1:0];
        // The accumulator carry stretches the next period by one cycle.
        per_d     = {1'b0, div_q} + CNT_W'(acc_sum[FRAC_W]);
        os_tick_d = 1'b1;
        if (ovs_cnt_q == OVS_W'(OVS - 1)) begin
          bd_tick_d = 1'b1;
          ovs_cnt_d = '0;
        end else begin
          ovs_cnt_d = ovs_cnt_q + OVS_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= DIV_W'(DEF_DIV);
      frac_q    <= FRAC_W'(DEF_FRAC);
      acc_q     <= '0;
      cnt_q     <= '0;
      per_q     <= CNT_W'(DEF_DIV);
      ovs_cnt_q <= '0;
      os_tick_q <= 1'b0;
      bd_tick_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      frac_q    <= frac_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      ovs_cnt_q <= ovs_cnt_d;
      os_tick_q <= os_tick_d;
      bd_tick_q <= bd_tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.os_tick = os_tick_q;
  assign bus.bd_tick = bd_tick_q;
  assign bus.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: stimulus queues expected tick cycles,
// a monitor pops and compares them whenever the DUT issues a tick.
module tb_baud_gen_frac;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_bd = -1;

  typedef struct {
    int cyc;
    bit bd;
  } exp_t;
  exp_t exp_q[$];

  baud_gen_frac_if #(.DIV_W(16), .FRAC_W(4)) bus ();

  baud_gen_frac #(
    .DIV_W(16), .FRAC_W(4), .OVS(16), .DEF_DIV(10), .DEF_FRAC(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_tick(input int c, input bit bd);
    exp_t e;
    e.cyc = c;
    e.bd  = bd;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_load(input int di, input int df);
    bus.div_int  = 16'(di);
    bus.div_frac = 4'(df);
    bus.div_load = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
  endtask

  // Monitor: cyc counts rising edges; outputs are sampled 1 time unit after each edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (bus.bd_tick) begin
      last_bd = cyc;
      check("bd_with_os", int'(bus.os_tick), 1);
    end
    if (bus.os_tick) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL tick_unexpected: got tick at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_bd", int'(bus.bd_tick), int'(e.bd));
      end
    end
  end

  initial begin
    int base;
    int t;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_int  = '0;
    bus.div_frac = '0;

    // Default rate out of reset
    repeat (2) @(negedge clk);
    check("rst_os_tick", int'(bus.os_tick), 0);
    check("rst_bd_tick", int'(bus.bd_tick), 0);
    check("rst_cfg_err", int'(bus.cfg_err), 0);
    rst    = 1'b0;
    bus.en = 1'b1;
    base   = cyc;
    for (int k = 1; k <= 40; k++) push_tick(base + 10 * k, (k % 16) == 0);
    wait_until(base + 400);
    check("default_bd_second", last_bd, base + 320);
    check("default_missing", exp_q.size(), 0);

    // Fractional divisor 10 + 8/16
    do_load(10, 8);
    base = cyc;
    t    = base;
    for (int k = 1; k <= 32; k++) begin
      t += (k == 1) ? 10 : (((k % 2) == 1) ? 11 : 10);
      push_tick(t, (k % 16) == 0);
    end
    wait_until(base + 167);
    check("frac_bd_first", last_bd, base + 167);
    wait_until(base + 335);
    check("frac_bd_second", last_bd, base + 335);
    check("frac_missing", exp_q.size(), 0);

    // Enable gating mid-period
    do_load(10, 0);
    base = cyc;
    push_tick(base + 10, 1'b0);
    push_tick(base + 27, 1'b0);
    for (int k = 3; k <= 16; k++) push_tick(base + 27 + 10 * (k - 2), k == 16);
    wait_until(base + 15);
    bus.en = 1'b0;
    wait_until(base + 22);
    bus.en = 1'b1;
    wait_until(base + 167);
    check("gate_bd_phase", last_bd, base + 167);
    check("gate_missing", exp_q.size(), 0);

    // Illegal divisor clamps to 2, legal divisor clears the flag
    do_load(1, 0);
    base = cyc;
    check("cfg_err_set", int'(bus.cfg_err), 1);
    for (int k = 1; k <= 10; k++) push_tick(base + 2 * k, 1'b0);
    wait_until(base + 20);
    do_load(4, 0);
    base = cyc;
    check("cfg_err_clear", int'(bus.cfg_err), 0);
    for (int k = 1; k <= 20; k++) push_tick(base + 4 * k, k == 16);
    wait_until(base + 80);
    check("div4_missing", exp_q.size(), 0);

    // Load on the cycle a tick is due
    wait_until(base + 83);
    do_load(6, 0);
    base = cyc;
    for (int k = 1; k <= 23; k++) push_tick(base + 6 * k, k == 16);
    wait_until(base + 96);
    check("wrapload_bd", last_bd, base + 96);

    // Reset while ovs_cnt is 7 and a tick is due
    wait_until(base + 143);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_os_tick", int'(bus.os_tick), 0);
    check("midrst_bd_tick", int'(bus.bd_tick), 0);
    check("midrst_cfg_err", int'(bus.cfg_err), 0);
    check("midrst_missing", exp_q.size(), 0);
    rst  = 1'b0;
    base = cyc;
    for (int k = 1; k <= 16; k++) push_tick(base + 10 * k, k == 16);
    wait_until(base + 165);
    check("postrst_bd", last_bd, base + 160);
    check("postrst_missing", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
